membus_arbiter: RTL and testbench

- Shares the single-ported memory bus (main RAM, character ROM) between the CPU register-bus master and NUM_RND renderer bus masters (layer 1, layer 2, sprites).
- Replaces the fixed-priority inline mux in the top level.
- CPU has priority, bounded by a starvation guard; renderers are served round-robin.
- Acks are aligned to the one-cycle synchronous memory read latency, so requesters sample read data on ack.

---
 rtl/membus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_membus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// membus_arbiter: shares the single-ported memory bus between the CPU
// register-bus master and NUM_RND renderer masters. The grant is decided
// combinationally each cycle. Acks are registered so they line up with the
// one-cycle synchronous read latency of the memory.
// Optional build macro: MEMBUS_ARB_STATS_EN adds the busy/stall counters and
// the stat_clear / stat_busy / stat_stall ports.
module membus_arbiter #(
  parameter int NUM_RND     = 2,
  parameter int CPU_MAX_RUN = 4
) (
  input  logic                  clk25,
  input  logic                  reset,
  input  logic [17:0]           cpu_addr,
  input  logic                  cpu_write,
  input  logic                  cpu_strobe,
  output logic                  cpu_ack,
  input  logic [NUM_RND*18-1:0] rnd_addr,
  input  logic [NUM_RND-1:0]    rnd_strobe,
  output logic [NUM_RND-1:0]    rnd_ack,
  output logic [17:0]           mem_addr,
  output logic                  mem_write,
  output logic                  mem_strobe,
  output logic [2:0]            mem_grant_id
`ifdef MEMBUS_ARB_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [15:0]           stat_busy,
  output logic [15:0]           stat_stall
`endif
);

  localparam logic [3:0] MAX_RUN  = 4'(CPU_MAX_RUN);
  localparam logic [1:0] LAST_RND = 2'(NUM_RND - 1);

  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [3:0]         run_cnt_q, run_cnt_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic [NUM_RND-1:0] rnd_ack_q, rnd_ack_d;
  logic [2:0]         grant_id_q, grant_id_d;

  logic               any_rnd;
  logic [1:0]         rnd_sel;
  logic [17:0]        rnd_sel_addr;
  logic               grant_cpu;
  logic               grant_rnd;
  int                 best_dist;
  int                 cur_dist;

  // Round-robin pick: requesting renderer closest to rr_ptr going upward.
  always_comb begin
    any_rnd      = |rnd_strobe;
    rnd_sel      = 2'd0;
    rnd_sel_addr = 18'd0;
    best_dist    = NUM_RND;
    cur_dist     = 0;
    for (int i = 0; i < NUM_RND; i++) begin
      cur_dist = (i + NUM_RND - int'(rr_ptr_q)) % NUM_RND;
      if (rnd_strobe[i] && (cur_dist < best_dist)) begin
        best_dist = cur_dist;
        rnd_sel   = 2'(i);
      end
    end
    for (int i = 0; i < NUM_RND; i++) begin
      if (2'(i) == rnd_sel) rnd_sel_addr = rnd_addr[18*i +: 18];
    end
  end

  // Grant decision, memory-side drive and next values of the registered state.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_rnd  = 1'b0;
    mem_strobe = 1'b0;
    mem_addr   = 18'd0;
    mem_write  = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    run_cnt_d  = 4'd0;
    cpu_ack_d  = 1'b0;
    rnd_ack_d  = '0;
    grant_id_d = 3'd0;

    // The starvation guard only holds the CPU back while a renderer waits.
    if (!reset) begin
      if (cpu_strobe && (run_cnt_q < MAX_RUN)) grant_cpu = 1'b1;
      else if (any_rnd)                        grant_rnd = 1'b1;
      else if (cpu_strobe)                     grant_cpu = 1'b1;
    end

    if (grant_cpu) begin
      mem_strobe = 1'b1;
      mem_addr   = cpu_addr;
      mem_write  = cpu_write;
      cpu_ack_d  = 1'b1;
      grant_id_d = 3'd1;
      if (any_rnd) begin
        run_cnt_d = (run_cnt_q >= MAX_RUN) ? MAX_RUN : run_cnt_q + 4'd1;
      end
    end else if (grant_rnd) begin
      mem_strobe = 1'b1;
      mem_addr   = rnd_sel_addr;
      grant_id_d = 3'd2 + {1'b0, rnd_sel};
      rr_ptr_d   = (rnd_sel == LAST_RND) ? 2'd0 : rnd_sel + 2'd1;
      for (int i = 0; i < NUM_RND; i++) begin
        rnd_ack_d[i] = (2'(i) == rnd_sel);
      end
    end
  end

  // Arbitration state and acks; acks land one cycle after the grant.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= 2'd0;
      run_cnt_q  <= 4'd0;
      cpu_ack_q  <= 1'b0;
      rnd_ack_q  <= '0;
      grant_id_q <= 3'd0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      run_cnt_q  <= run_cnt_d;
      cpu_ack_q  <= cpu_ack_d;
      rnd_ack_q  <= rnd_ack_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign cpu_ack      = cpu_ack_q;
  assign rnd_ack      = rnd_ack_q;
  assign mem_grant_id = grant_id_q;

`ifdef MEMBUS_ARB_STATS_EN
  logic [15:0] busy_q, busy_d;
  logic [15:0] stall_q, stall_d;
  logic        stall_now;

  // Saturating usage counters; a clear takes precedence over counting.
  always_comb begin
    stall_now = (cpu_strobe && !grant_cpu) || (|(rnd_strobe & ~rnd_ack_d));
    busy_d    = busy_q;
    stall_d   = stall_q;
    if (stat_clear) begin
      busy_d  = 16'd0;
      stall_d = 16'd0;
    end else begin
      if (mem_strobe && (busy_q != 16'hFFFF))  busy_d  = busy_q + 16'd1;
      if (stall_now && (stall_q != 16'hFFFF))  stall_d = stall_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      busy_q  <= 16'd0;
      stall_q <= 16'd0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign stat_busy  = busy_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter (NUM_RND = 2, CPU_MAX_RUN = 4): directed scenarios
// with literal expectations, then randomized traffic against a reference model.
module tb_membus_arbiter;

  localparam int NR   = 2;
  localparam int MAXR = 4;

  logic          clk25 = 1'b0;
  logic          reset;
  logic [17:0]   cpu_addr;
  logic          cpu_write;
  logic          cpu_strobe;
  logic          cpu_ack;
  logic [NR*18-1:0] rnd_addr;
  logic [NR-1:0] rnd_strobe;
  logic [NR-1:0] rnd_ack;
  logic [17:0]   mem_addr;
  logic          mem_write;
  logic          mem_strobe;
  logic [2:0]    mem_grant_id;
`ifdef MEMBUS_ARB_STATS_EN
  logic          stat_clear;
  logic [15:0]   stat_busy;
  logic [15:0]   stat_stall;
`endif

  int errors = 0;
  int checks = 0;

  membus_arbiter #(.NUM_RND(NR), .CPU_MAX_RUN(MAXR)) dut (
    .clk25(clk25), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_strobe(cpu_strobe), .cpu_ack(cpu_ack),
    .rnd_addr(rnd_addr), .rnd_strobe(rnd_strobe), .rnd_ack(rnd_ack),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_strobe(mem_strobe),
    .mem_grant_id(mem_grant_id)
`ifdef MEMBUS_ARB_STATS_EN
    , .stat_clear(stat_clear), .stat_busy(stat_busy), .stat_stall(stat_stall)
`endif
  );

  always #20 clk25 = ~clk25;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner of the previous cycle: 0 none, 1 CPU, 2+i renderer i.
  int m_prev = 0;
  int m_rr   = 0;
  int m_run  = 0;
`ifdef MEMBUS_ARB_STATS_EN
  int m_busy  = 0;
  int m_stall = 0;
`endif

  always @(negedge clk25) begin
    int w;
    int idx;
    logic [17:0] exp_addr;
    logic [NR-1:0] exp_rack;
    if (reset) begin
      chk("rst_mem_strobe", {31'd0, mem_strobe}, 32'd0);
      chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
      chk("rst_rnd_ack", 32'(rnd_ack), 32'd0);
      chk("rst_grant_id", 32'(mem_grant_id), 32'd0);
      m_prev = 0; m_rr = 0; m_run = 0;
`ifdef MEMBUS_ARB_STATS_EN
      m_busy = 0; m_stall = 0;
      chk("rst_stat_busy", 32'(stat_busy), 32'd0);
`endif
    end else begin
      exp_rack = '0;
      if (m_prev >= 2) exp_rack[m_prev-2] = 1'b1;
      chk("m_cpu_ack", {31'd0, cpu_ack}, {31'd0, (m_prev == 1)});
      chk("m_rnd_ack", 32'(rnd_ack), 32'(exp_rack));
      chk("m_grant_id", 32'(mem_grant_id), 32'(m_prev));

      w = 0;
      if (cpu_strobe && m_run < MAXR) w = 1;
      else begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_rr + k) % NR;
          if (w == 0 && rnd_strobe[idx]) w = 2 + idx;
        end
        if (w == 0 && cpu_strobe) w = 1;
      end

      exp_addr = 18'd0;
      if (w == 1) exp_addr = cpu_addr;
      else if (w >= 2) exp_addr = 18'(rnd_addr >> (18 * (w - 2)));
      chk("m_mem_strobe", {31'd0, mem_strobe}, {31'd0, (w != 0)});
      chk("m_mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("m_mem_write", {31'd0, mem_write}, {31'd0, (w == 1) && cpu_write});

`ifdef MEMBUS_ARB_STATS_EN
      chk("m_stat_busy", 32'(stat_busy), 32'(m_busy));
      chk("m_stat_stall", 32'(stat_stall), 32'(m_stall));
      if (stat_clear) begin
        m_busy = 0; m_stall = 0;
      end else begin
        if (w != 0 && m_busy < 65535) m_busy++;
        if (((cpu_strobe && w != 1) || (rnd_strobe != 0 && (w < 2 ||
             rnd_strobe != (NR'(1) << (w - 2))))) && m_stall < 65535) m_stall++;
      end
`endif

      if (w == 1) m_run = (rnd_strobe != 0) ? ((m_run + 1 > MAXR) ? MAXR : m_run + 1) : 0;
      else m_run = 0;
      if (w >= 2) m_rr = (w - 2 + 1) % NR;
      m_prev = w;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk25);
    #2;
  endtask

  task automatic drive(input logic cs, input logic cw, input logic [17:0] ca,
                       input logic [NR-1:0] rs, input logic [17:0] a0, input logic [17:0] a1);
    cpu_strobe = cs;
    cpu_write  = cw;
    cpu_addr   = ca;
    rnd_strobe = rs;
    rnd_addr   = {a1, a0};
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 18'd0, 2'b00, 18'd0, 18'd0);
`ifdef MEMBUS_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(posedge clk25);
    #2 reset = 1'b0;

    // CPU read alone: grant now, ack one cycle later only.
    drive(1'b1, 1'b0, 18'h01234, 2'b00, 18'd0, 18'd0);
    #8;
    chk("t1_strobe", {31'd0, mem_strobe}, 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h01234);
    chk("t1_no_ack_yet", {31'd0, cpu_ack}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 18'h01234, 2'b00, 18'd0, 18'd0);
    #8;
    chk("t1_ack", {31'd0, cpu_ack}, 32'd1);
    chk("t1_id", 32'(mem_grant_id), 32'd1);
    chk("t1_idle", {31'd0, mem_strobe}, 32'd0);
    next_cycle();
    #8;
    chk("t1_ack_gone", {31'd0, cpu_ack}, 32'd0);
    chk("t1_id_gone", 32'(mem_grant_id), 32'd0);

    // Two renderers held high: strict alternation starting at R0.
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      drive(1'b0, 1'b0, 18'd0, 2'b11, 18'h00100, 18'h00200);
      #8;
      chk("t2_addr", 32'(mem_addr), (k % 2 == 0) ? 32'h100 : 32'h200);
      if (k > 0) chk("t2_ack", 32'(rnd_ack), (k % 2 == 0) ? 32'd2 : 32'd1);
    end
    next_cycle();
    drive(1'b0, 1'b0, 18'd0, 2'b00, 18'd0, 18'd0);
    #8;
    chk("t2_last_ack", 32'(rnd_ack), 32'd2);

    // CPU and R0 both held: four CPU grants then one R0 grant, repeating.
`ifdef MEMBUS_ARB_STATS_EN
    next_cycle();
    stat_clear = 1'b1;
    next_cycle();
    stat_clear = 1'b0;
`endif
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      drive(1'b1, 1'b0, 18'h03000, 2'b01, 18'h00111, 18'h00222);
      #8;
      chk("t3_addr", 32'(mem_addr), (k % 5 == 4) ? 32'h111 : 32'h3000);
    end
    next_cycle();
    drive(1'b0, 1'b0, 18'd0, 2'b00, 18'd0, 18'd0);
`ifdef MEMBUS_ARB_STATS_EN
    stat_clear = 1'b1;
    #8;
    chk("t6_busy", 32'(stat_busy), 32'd10);
    chk("t6_stall", 32'(stat_stall), 32'd10);
    next_cycle();
    stat_clear = 1'b0;
    #8;
    chk("t6_busy_clr", 32'(stat_busy), 32'd0);
    chk("t6_stall_clr", 32'(stat_stall), 32'd0);
`endif

    // CPU write beside an R1 request: write enable only on the CPU grant.
    next_cycle();
    drive(1'b1, 1'b1, 18'h00010, 2'b10, 18'h00111, 18'h00222);
    #8;
    chk("t4_write", {31'd0, mem_write}, 32'd1);
    chk("t4_addr", 32'(mem_addr), 32'h10);
    next_cycle();
    drive(1'b0, 1'b0, 18'h00010, 2'b10, 18'h00111, 18'h00222);
    #8;
    chk("t4_r1_write", {31'd0, mem_write}, 32'd0);
    chk("t4_r1_addr", 32'(mem_addr), 32'h222);
    chk("t4_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 18'd0, 2'b00, 18'd0, 18'd0);
    #8;
    chk("t4_r1_ack", 32'(rnd_ack), 32'd2);

    // Reset with an ack in flight; afterwards R0 wins a tie again.
    next_cycle();
    drive(1'b0, 1'b0, 18'd0, 2'b01, 18'h00111, 18'h00222);
    #8;
    chk("t5_r0", 32'(mem_addr), 32'h111);
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 1'b0, 18'd0, 2'b11, 18'h00111, 18'h00222);
    #8;
    chk("t5_rnd_ack", 32'(rnd_ack), 32'd0);
    chk("t5_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("t5_strobe", {31'd0, mem_strobe}, 32'd0);
    next_cycle();
    reset = 1'b0;
    #8;
    chk("t5_tie", 32'(mem_addr), 32'h111);
    chk("t5_tie_strobe", {31'd0, mem_strobe}, 32'd1);

    // Randomized traffic, strongly biased toward contention.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 7, 1'($urandom), 18'($urandom),
            NR'($urandom), 18'($urandom), 18'($urandom));
      if ($urandom_range(0, 3) == 0) rnd_strobe = 2'b11;
`ifdef MEMBUS_ARB_STATS_EN
      stat_clear = ($urandom_range(0, 99) == 0);
`endif
    end
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 1'b0, 18'd0, 2'b00, 18'd0, 18'd0);
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
